// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline hazard/flush control with a multi-cycle data-memory
//               freeze FSM. Define PIPE_PERF_CNT_EN to enable the saturating
//               stall/flush/wait performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MEM_LAT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src1,
    input  logic [3:0]  src2,
    input  logic        two_src,
    input  logic        id_valid,
    input  logic        exe_wb_en,
    input  logic [3:0]  exe_dest,
    input  logic        exe_b,
    input  logic        mem_wb_en,
    input  logic [3:0]  mem_dest,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    output logic        hazard,
    output logic        flush,
    output logic        freeze,
    output logic        mem_ready,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
    output logic [31:0] wait_cnt
);

    localparam logic [3:0] c_LAT_LOAD = 4'(MEM_LAT - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       w_mem_req;
    logic       w_raw1;
    logic       w_raw2;
    logic       w_raw;

    assign w_mem_req = mem_r_en | mem_w_en;

    assign w_raw1 = id_valid & ((exe_wb_en & (exe_dest == src1)) |
                                (mem_wb_en & (mem_dest == src1)));
    assign w_raw2 = two_src  & ((exe_wb_en & (exe_dest == src2)) |
                                (mem_wb_en & (mem_dest == src2)));
    assign w_raw  = w_raw1 | w_raw2;

    assign freeze    = ((r_state == ST_IDLE) & w_mem_req) | (r_state == ST_WAIT);
    assign mem_ready = (r_state == ST_DONE);
    assign hazard    = w_raw & ~exe_b & ~freeze;
    // A branch parked in EXE during a freeze is released once the freeze ends.
    assign flush     = exe_b & ~freeze;

    // The counter holds the WAIT cycles still to run, so the access is frozen
    // for the IDLE request cycle plus MEM_LAT-2 WAIT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_req) begin
                        r_cnt   <= c_LAT_LOAD;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_wait_cnt;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
            r_wait_cnt  <= 32'd0;
        end else begin
            if (hazard && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (flush && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
            if (freeze && (r_wait_cnt != 32'hFFFF_FFFF))
                r_wait_cnt <= r_wait_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign wait_cnt  = r_wait_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
    assign wait_cnt  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl (MEM_LAT=6).
//               Counter values are checked against PIPE_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic        id_valid;
    logic        exe_wb_en;
    logic [3:0]  exe_dest;
    logic        exe_b;
    logic        mem_wb_en;
    logic [3:0]  mem_dest;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        hazard;
    logic        flush;
    logic        freeze;
    logic        mem_ready;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] wait_cnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.MEM_LAT(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .src1      (src1),
        .src2      (src2),
        .two_src   (two_src),
        .id_valid  (id_valid),
        .exe_wb_en (exe_wb_en),
        .exe_dest  (exe_dest),
        .exe_b     (exe_b),
        .mem_wb_en (mem_wb_en),
        .mem_dest  (mem_dest),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .hazard    (hazard),
        .flush     (flush),
        .freeze    (freeze),
        .mem_ready (mem_ready),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .wait_cnt  (wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

`ifdef PIPE_PERF_CNT_EN
    localparam bit c_CNT_EN = 1'b1;
`else
    localparam bit c_CNT_EN = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src1 = 4'd0; src2 = 4'd0; two_src = 1'b0; id_valid = 1'b0;
        exe_wb_en = 1'b0; exe_dest = 4'd0; exe_b = 1'b0;
        mem_wb_en = 1'b0; mem_dest = 4'd0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze got %b exp 0", freeze); end
        checks++;
        if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", mem_ready); end
        checks++;
        if ({hazard, flush} !== 2'b00) begin errors++; $display("FAIL reset_hz_fl got %b exp 00", {hazard, flush}); end
        checks++;
        if ({stall_cnt, flush_cnt, wait_cnt} !== 96'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d/%0d exp 0/0/0", stall_cnt, flush_cnt, wait_cnt);
        end
        tick();
    endtask

    task automatic test_raw();
        clear_inputs();
        src1 = 4'd3; id_valid = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
        #1;
        checks++;
        if ({hazard, flush} !== 2'b10) begin errors++; $display("FAIL raw_exe_src1 got %b exp 10", {hazard, flush}); end
        exe_dest = 4'd4; mem_wb_en = 1'b1; mem_dest = 4'd5;
        #1;
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("FAIL raw_none got %b exp 0", hazard); end
        src2 = 4'd5; two_src = 1'b1;
        #1;
        checks++;
        if (hazard !== 1'b1) begin errors++; $display("FAIL raw_mem_src2 got %b exp 1", hazard); end
        two_src = 1'b0;
        #1;
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("FAIL raw_src2_unused got %b exp 0", hazard); end
        mem_dest = 4'd3;
        #1;
        checks++;
        if (hazard !== 1'b1) begin errors++; $display("FAIL raw_mem_src1 got %b exp 1", hazard); end
        mem_wb_en = 1'b0;
        #1;
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("FAIL raw_mem_nowb got %b exp 0", hazard); end
        id_valid = 1'b0; exe_dest = 4'd3; exe_wb_en = 1'b1;
        #1;
        checks++;
        if (hazard !== 1'b0) begin errors++; $display("FAIL raw_id_invalid got %b exp 0", hazard); end
        clear_inputs();
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        src1 = 4'd3; id_valid = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3; exe_b = 1'b1;
        #1;
        checks++;
        if ({hazard, flush} !== 2'b01) begin errors++; $display("FAIL branch_prio got %b exp 01", {hazard, flush}); end
        clear_inputs();
        tick();
    endtask

    // Access from cycle 0, request held through a back-to-back second access
    // and dropped mid-WAIT of that second access.
    task automatic test_mem_access();
        logic exp_fr;
        logic exp_rd;
        clear_inputs();
        mem_r_en = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            exp_fr = (c <= 4) || (c >= 6 && c <= 10);
            exp_rd = (c == 5) || (c == 11);
            @(negedge clk);
            checks++;
            if (freeze !== exp_fr) begin errors++; $display("FAIL mem_freeze c%0d got %b exp %b", c, freeze, exp_fr); end
            checks++;
            if (mem_ready !== exp_rd) begin errors++; $display("FAIL mem_ready c%0d got %b exp %b", c, mem_ready, exp_rd); end
            tick();
            if (c == 6) mem_r_en = 1'b0;
        end
        clear_inputs();
    endtask

    task automatic test_branch_freeze();
        logic exp_fl;
        clear_inputs();
        mem_w_en = 1'b1;
        src1 = 4'd3; id_valid = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3;
        for (int c = 0; c <= 5; c++) begin
            if (c == 2) exe_b = 1'b1;
            if (c == 1) mem_w_en = 1'b0;
            exp_fl = (c == 5);
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if (flush !== exp_fl) begin errors++; $display("FAIL brfrz_flush c%0d got %b exp %b", c, flush, exp_fl); end
            end
            checks++;
            if (hazard !== 1'b0) begin errors++; $display("FAIL brfrz_hazard c%0d got %b exp 0", c, hazard); end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        mem_r_en = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        rst = 1'b1;
        mem_r_en = 1'b0;
        tick();
        rst = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if ({freeze, mem_ready} !== 2'b00) begin
                errors++; $display("FAIL rstwait c%0d fr/rd got %b exp 00", c, {freeze, mem_ready});
            end
            if (c == 4) begin
                checks++;
                if ({stall_cnt, flush_cnt, wait_cnt} !== 96'd0) begin
                    errors++; $display("FAIL rstwait_cnt got %0d/%0d/%0d exp 0/0/0", stall_cnt, flush_cnt, wait_cnt);
                end
            end
            tick();
        end
    endtask

    task automatic test_counters();
        logic [31:0] e_st;
        logic [31:0] e_fl;
        logic [31:0] e_wt;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        src1 = 4'd7; id_valid = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd7;
        for (int i = 0; i < 3; i++) tick();
        clear_inputs();
        exe_b = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        clear_inputs();
        mem_r_en = 1'b1;
        tick();
        mem_r_en = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        e_st = c_CNT_EN ? 32'd3 : 32'd0;
        e_fl = c_CNT_EN ? 32'd2 : 32'd0;
        e_wt = c_CNT_EN ? 32'd5 : 32'd0;
        @(negedge clk);
        checks++;
        if (stall_cnt !== e_st) begin errors++; $display("FAIL cnt_stall got %0d exp %0d", stall_cnt, e_st); end
        checks++;
        if (flush_cnt !== e_fl) begin errors++; $display("FAIL cnt_flush got %0d exp %0d", flush_cnt, e_fl); end
        checks++;
        if (wait_cnt !== e_wt) begin errors++; $display("FAIL cnt_wait got %0d exp %0d", wait_cnt, e_wt); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_raw();
        test_branch();
        test_mem_access();
        test_branch_freeze();
        test_reset_mid_wait();
        test_counters();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
